// File: rtl/switch_box_cfg_loader_if.sv
// Valid/ready word stream carrying switch-box configuration words, word 0 first.
interface switch_box_cfg_loader_if #(
    parameter int unsigned DW = 8
);
    logic          cfg_valid;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/switch_box_cfg_loader.sv
// Streams a route-select vector into a shadow register, rejects illegal 2-bit selects,
// and commits legal vectors to the active config in a single cycle.
module switch_box_cfg_loader #(
    parameter int unsigned W  = 8,
    parameter int unsigned DW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    switch_box_cfg_loader_if.slave  cfg,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [W*8-1:0]          c
);
    localparam int unsigned CW   = W * 8;
    localparam int unsigned NW   = CW / DW;
    localparam int unsigned NF   = CW / 2;
    localparam int unsigned CntW = $clog2(NW + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   shadow_q, shadow_d;
    logic [CW-1:0]   c_d;
    logic            done_d, err_d;
    logic            illegal;

    // Select value 3 has no meaning in the switch-box encoding.
    always_comb begin
        illegal = 1'b0;
        for (int unsigned k = 0; k < NF; k++) begin
            if (shadow_q[2*k +: 2] == 2'b11) illegal = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        c_d      = c;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cfg.cfg_valid) begin
                    for (int unsigned i = 0; i < NW; i++) begin
                        if (cnt_q == CntW'(i)) shadow_d[i*DW +: DW] = cfg.cfg_data;
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(NW - 1)) state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StIdle;
                cnt_d   = '0;
                if (!abort) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        c_d    = shadow_q;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            c        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            c        <= c_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

    assign cfg.cfg_ready = (state_q == StLoad);
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// Randomized scoreboard bench for switch_box_cfg_loader (W=8, DW=8, eight words per load).
module tb_switch_box_cfg_loader;
    localparam int unsigned W  = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 8;

    typedef struct {
        logic        is_err;
        logic [63:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] c;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [63:0] model_c;
    logic [63:0] prev_c;
    logic [7:0]  wbuf [NW];

    switch_box_cfg_loader_if #(.DW(DW)) cfg_if ();

    switch_box_cfg_loader #(.W(W), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .cfg   (cfg_if.slave),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .c     (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every done/err pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("done_err_exclusive", done & err, 1'b0);
            check("pulse_while_busy", busy & (done | err), 1'b0);
            check("c_atomic", (c !== prev_c) && !done, 1'b0);
            if (done || err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got done=%0d err=%0d, expected none",
                             done, err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (err !== e.is_err || done !== !e.is_err) begin
                        errors++;
                        $display("FAIL pulse_kind: got done=%0d err=%0d, expected err=%0d",
                                 done, err, e.is_err);
                    end
                    check("c_after_pulse", c, e.c);
                end
            end
        end
        prev_c = c;
    end

    task automatic gen_legal();
        for (int i = 0; i < NW; i++) begin
            wbuf[i] = 8'h00;
            for (int j = 0; j < 4; j++) wbuf[i] |= 8'($urandom_range(0, 2)) << (2 * j);
        end
    endtask

    task automatic gen_random();
        for (int i = 0; i < NW; i++) wbuf[i] = 8'($urandom);
    endtask

    // vmode: 0 valid held high, 1 alternating, 2 random.
    // abort_at: 1..NW aborts with that word's handshake, NW+1 aborts in CHECK, else none.
    task automatic do_load(input int vmode, input int abort_at);
        int          n;
        int          cyc;
        logic        hs;
        logic        bad;
        logic [63:0] img;
        exp_t        e;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_accept_busy", busy, 1'b1);
        n   = 0;
        cyc = 0;
        while (n < NW && cyc < 100) begin
            case (vmode)
                0:       cfg_if.cfg_valid = 1'b1;
                1:       cfg_if.cfg_valid = (cyc % 2 == 0);
                default: cfg_if.cfg_valid = 1'($urandom_range(0, 1));
            endcase
            cfg_if.cfg_data = wbuf[n];
            start = 1'($urandom_range(0, 1));
            if (abort_at == n + 1) begin
                abort            = 1'b1;
                cfg_if.cfg_valid = 1'b1;
            end
            hs = cfg_if.cfg_valid && cfg_if.cfg_ready;
            tick();
            if (hs) n++;
            cyc++;
            if (abort) begin
                abort            = 1'b0;
                cfg_if.cfg_valid = 1'b0;
                start            = 1'b0;
                check("abort_load_idle", busy, 1'b0);
                check("abort_load_c", c, model_c);
                return;
            end
        end
        cfg_if.cfg_valid = 1'b0;
        if (n < NW) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d words, expected %0d", n, NW);
            start = 1'b0;
            return;
        end
        if (vmode == 0) check("b2b_cycles", 64'(cyc), 64'(NW));
        if (vmode == 1) check("bubble_cycles", 64'(cyc), 64'(2 * NW - 1));
        check("check_ready_low", cfg_if.cfg_ready, 1'b0);
        check("check_busy", busy, 1'b1);
        img = '0;
        bad = 1'b0;
        for (int i = 0; i < NW; i++) begin
            img = img | (64'(wbuf[i]) << (8 * i));
            for (int j = 0; j < 4; j++) if (((wbuf[i] >> (2 * j)) & 8'd3) == 8'd3) bad = 1'b1;
        end
        if (abort_at == NW + 1) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            check("abort_check_idle", busy, 1'b0);
            check("abort_check_c", c, model_c);
            return;
        end
        e.is_err = bad;
        if (!bad) model_c = img;
        e.c = model_c;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        check("pulse_after_check", done | err, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        model_c          = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_c", c, 64'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", cfg_if.cfg_ready, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("idle_abort_no_effect_pre", busy, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_no_effect", busy, 1'b0);

        // Legal 0x24 load, then one with word 5 carrying an illegal select.
        for (int i = 0; i < NW; i++) wbuf[i] = 8'h24;
        do_load(0, 0);
        check("legal_c_const", c, 64'h2424_2424_2424_2424);
        wbuf[5] = 8'h30;
        do_load(0, 0);
        check("illegal_c_kept", c, 64'h2424_2424_2424_2424);

        gen_legal();
        do_load(1, 0);
        gen_legal();
        do_load(0, NW);
        gen_legal();
        do_load(0, 0);
        gen_legal();
        do_load(0, NW + 1);
        gen_legal();
        do_load(2, 0);

        for (int t = 0; t < 30; t++) begin
            int ab;
            if ($urandom_range(0, 1) == 0) gen_legal();
            else gen_random();
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, NW + 1)) : 0;
            do_load(int'($urandom_range(0, 2)), ab);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end

        // Asynchronous reset in the middle of a load.
        gen_legal();
        start = 1'b1;
        tick();
        start            = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = wbuf[0];
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        model_c = '0;
        check("async_reset_c", c, 64'h0);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_ready", cfg_if.cfg_ready, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", busy, 1'b0);
        gen_legal();
        do_load(0, 0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
